mul_seq_ctrl: RTL

//   Control FSM for the shift-add multiplier datapath (product register + ALU).

---
 rtl/mul_seq_ctrl_if.sv | 26 ++
 rtl/mul_seq_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Handshake bundle between the shift-add multiplier controller and its
// surroundings: requests in, datapath controls and status out.
interface mul_seq_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic             abort;
  logic             lsb;
  logic             w_ctrl;
  logic             srl_ctrl;
  logic             alu_add;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, abort, lsb,
    input  w_ctrl, srl_ctrl, alu_add, ready, busy, done, iter_cnt
  );

  modport slave (
    input  start, abort, lsb,
    output w_ctrl, srl_ctrl, alu_add, ready, busy, done, iter_cnt
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Control FSM for a shift-add multiplier: one load cycle, WIDTH add/shift
// iterations, then a one-cycle done pulse. Outputs registered except alu_add.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           reset,
  mul_seq_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             w_ctrl_q, srl_ctrl_q, ready_q, busy_q, done_q;

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = bus.abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_ITER) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register without an extra cycle of latency.
  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      w_ctrl_q   <= 1'b0;
      srl_ctrl_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      w_ctrl_q   <= (state_nxt == LOAD);
      srl_ctrl_q <= (state_nxt == SHIFT);
      ready_q    <= (state_nxt == IDLE) || (state_nxt == DONE);
      busy_q     <= (state_nxt == LOAD) || (state_nxt == SHIFT);
      done_q     <= (state_nxt == DONE);
    end
  end

  assign bus.w_ctrl   = w_ctrl_q;
  assign bus.srl_ctrl = srl_ctrl_q;
  assign bus.alu_add  = srl_ctrl_q & bus.lsb;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter_cnt = cnt;

endmodule
